// File: rtl/rdma_aes_key_arb.sv
// Round-robin key-load arbiter for the shared RDMA AES engine.
// Skips reloads of a resident key and aborts a stalled expansion on timeout.
module rdma_aes_key_arb #(
  parameter int N_REQ          = 4,
  parameter int PID_BITS       = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int PW            = $clog2(N_REQ),
  localparam int CW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*PID_BITS-1:0] req_ctid,
  input  logic [N_REQ*128-1:0]      req_key,
  output logic [127:0]              key_out,
  output logic                      keyStart,
  input  logic                      key_done,
  output logic [PID_BITS-1:0]       mux_ctid,
  output logic                      key_valid,
  input  logic                      flush,
  output logic [PW-1:0]             grant_id,
  output logic                      busy,
  output logic                      err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [PW-1:0]       rr_ptr;
  logic [CW-1:0]       cnt;
  logic                found;
  logic [PW-1:0]       win;
  logic [PID_BITS-1:0] sel_ctid;
  logic [127:0]        sel_key;
  logic                accept;
  logic                hit;
  logic                term;
  logic                is_idle;
  logic                is_start;
  logic                is_wait;

  assign is_idle  = (state_q == IDLE);
  assign is_start = (state_q == START);
  assign is_wait  = (state_q == WAIT);

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign sel_ctid = req_ctid[int'(win)*PID_BITS +: PID_BITS];
  assign sel_key  = req_key[int'(win)*128 +: 128];

  assign accept = is_idle & found & ~flush;
  assign hit    = key_valid & (sel_ctid == mux_ctid) &
                  (sel_key == key_out);
  assign term   = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    req_ready = '0;
    if (is_idle && found && !flush && aresetn)
      req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (1'b1)
        is_idle:  if (accept && !hit) state_d = START;
        is_start: state_d = WAIT;
        is_wait:  if (key_done || term) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      key_out     <= '0;
      mux_ctid    <= '0;
      key_valid   <= 1'b0;
      keyStart    <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      keyStart    <= accept & ~hit;
      err_timeout <= is_wait & ~flush & ~key_done & term;
      busy        <= (state_d != IDLE);
      if (flush) begin
        key_valid <= 1'b0;
      end else if (accept) begin
        grant_id <= win;
        rr_ptr   <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
        if (!hit) begin
          key_out   <= sel_key;
          mux_ctid  <= sel_ctid;
          key_valid <= 1'b0;
        end
      end else if (is_wait && key_done) begin
        key_valid <= 1'b1;
      end
      // counter saturates instead of wrapping
      if (is_start)
        cnt <= '0;
      else if (is_wait && cnt != {CW{1'b1}})
        cnt <= cnt + 1'b1;
    end
  end

endmodule
